// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the multi-cycle control unit and the datapath.
// Contents: opcode encodings (OP_*), ALU operation codes (ALU_*), the control
// FSM state type, and the mux-select bundle produced by the opcode decoder.
package proc_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h02;
    localparam logic [5:0] OP_SW   = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h06;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Opcode-decoded mux selects. m1 (branch target) is absent because it
    // depends on the sampled branch outcome, not on the opcode alone.
    typedef struct packed {
        logic m2;
        logic m3;
        logic m4;
        logic m5;
        logic m6;
        logic m7;
    } sel_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction decoder for the multi-cycle control unit.
// Ports:
//   opcode     in  6  instruction opcode
//   funct      in  4  R-type ALU function
//   alu_funct  out 4  ALU operation for this instruction
//   sel        out    opcode-decoded mux selects m2..m7
//   is_mem     out 1  LW or SW (needs the S_MEM cycle)
//   is_store   out 1  SW
//   writes_reg out 1  R, ADDI or LW
//   is_branch  out 1  BEQ or BNE
//   is_bne     out 1  BNE (branch on not-zero)
//   is_halt    out 1  HALT
//   is_illegal out 1  opcode not in the instruction set
module mc_decode
    import proc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [3:0] funct,
    output logic [3:0] alu_funct,
    output sel_t       sel,
    output logic       is_mem,
    output logic       is_store,
    output logic       writes_reg,
    output logic       is_branch,
    output logic       is_bne,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        alu_funct  = ALU_ADD;
        sel        = '0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        writes_reg = 1'b0;
        is_branch  = 1'b0;
        is_bne     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                alu_funct  = funct;
                sel.m3     = 1'b1;
                sel.m4     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_ADDI: begin
                sel.m3     = 1'b1;
                sel.m6     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_LW: begin
                sel.m3     = 1'b1;
                sel.m6     = 1'b1;
                sel.m7     = 1'b1;
                is_mem     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SW: begin
                sel.m5   = 1'b1;
                sel.m6   = 1'b1;
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_BEQ: begin
                alu_funct = ALU_SUB;
                is_branch = 1'b1;
            end
            OP_BNE: begin
                alu_funct = ALU_SUB;
                is_branch = 1'b1;
                is_bne    = 1'b1;
            end
            OP_J:    sel.m2     = 1'b1;
            OP_HALT: is_halt    = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle control unit sequencing each instruction through a
// Moore FSM (S_FETCH -> S_EXEC -> [S_MEM] -> S_WB, or S_HALT).
// Ports:
//   clk, rst (sync, active-high)
//   run            in  1      start next instruction (sampled in S_FETCH only)
//   opcode, funct  in         instruction fields from the datapath
//   alu_zero       in  1      ALU zero flag, sampled in S_EXEC
//   pc_store, reg_block_w, dmem_w   out  one-cycle state-decoded strobes
//   alu_funct      out 4      ALU operation
//   m1_num..m7_num out 1 each datapath mux selects
//   halted         out 1      in S_HALT
//   illegal_op     out 1      sticky undefined-opcode flag
//   instr_retired  out CNT_W  retired-instruction count (wraps)
module mc_control
    import proc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [3:0]       funct,
    input  logic             alu_zero,
    output logic             pc_store,
    output logic             reg_block_w,
    output logic             dmem_w,
    output logic [3:0]       alu_funct,
    output logic             m1_num,
    output logic             m2_num,
    output logic             m3_num,
    output logic             m4_num,
    output logic             m5_num,
    output logic             m6_num,
    output logic             m7_num,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_retired
);

    state_t     state;
    logic       taken_q;
    logic [3:0] dec_alu_funct;
    sel_t       dec_sel;
    logic       is_mem, is_store, writes_reg, is_branch, is_bne, is_halt, is_illegal;
    logic       quiet;

    mc_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .alu_funct  (dec_alu_funct),
        .sel        (dec_sel),
        .is_mem     (is_mem),
        .is_store   (is_store),
        .writes_reg (writes_reg),
        .is_branch  (is_branch),
        .is_bne     (is_bne),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            taken_q       <= 1'b0;
            illegal_op    <= 1'b0;
            instr_retired <= '0;
        end else begin
            case (state)
                S_FETCH: if (run) state <= S_EXEC;
                S_EXEC: begin
                    // Branch outcome is frozen here so S_WB ignores the live flag.
                    taken_q <= is_branch & (is_bne ? ~alu_zero : alu_zero);
                    if (is_illegal) illegal_op <= 1'b1;
                    if (is_halt)     state <= S_HALT;
                    else if (is_mem) state <= S_MEM;
                    else             state <= S_WB;
                end
                S_MEM: state <= S_WB;
                S_WB: begin
                    instr_retired <= instr_retired + CNT_W'(1);
                    state         <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst so a reset mid-instruction emits nothing more.
    assign pc_store    = ~rst & (state == S_WB);
    assign reg_block_w = ~rst & (state == S_WB) & writes_reg;
    assign dmem_w      = ~rst & (state == S_MEM) & is_store;
    assign m1_num      = ~rst & (state == S_WB) & taken_q;
    assign halted      = (state == S_HALT);

    assign quiet     = rst | (state == S_HALT);
    assign alu_funct = quiet ? ALU_ADD : dec_alu_funct;
    assign m2_num    = ~quiet & dec_sel.m2;
    assign m3_num    = ~quiet & dec_sel.m3;
    assign m4_num    = ~quiet & dec_sel.m4;
    assign m5_num    = ~quiet & dec_sel.m5;
    assign m6_num    = ~quiet & dec_sel.m6;
    assign m7_num    = ~quiet & dec_sel.m7;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control. Each cycle's expected
// strobe/flag/counter vector is queued when an instruction is launched and
// popped and compared one time unit after each rising edge.
module tb_mc_control;
    import proc_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b1;
    logic [5:0]       opcode = '0;
    logic [3:0]       funct = '0;
    logic             alu_zero = 1'b0;
    logic             pc_store, reg_block_w, dmem_w;
    logic [3:0]       alu_funct;
    logic             m1_num, m2_num, m3_num, m4_num, m5_num, m6_num, m7_num;
    logic             halted, illegal_op;
    logic [CNT_W-1:0] instr_retired;

    mc_control #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .opcode        (opcode),
        .funct         (funct),
        .alu_zero      (alu_zero),
        .pc_store      (pc_store),
        .reg_block_w   (reg_block_w),
        .dmem_w        (dmem_w),
        .alu_funct     (alu_funct),
        .m1_num        (m1_num),
        .m2_num        (m2_num),
        .m3_num        (m3_num),
        .m4_num        (m4_num),
        .m5_num        (m5_num),
        .m6_num        (m6_num),
        .m7_num        (m7_num),
        .halted        (halted),
        .illegal_op    (illegal_op),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    // Vector layout: {pc_store, reg_block_w, dmem_w, m1_num, halted, illegal_op, instr_retired}
    typedef logic [6+CNT_W-1:0] vec_t;
    vec_t             sb[$];
    vec_t             e;
    int               vectors = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    logic             exp_ill = 1'b0;

    function automatic vec_t got();
        return {pc_store, reg_block_w, dmem_w, m1_num, halted, illegal_op, instr_retired};
    endfunction

    // st = {pc_store, reg_block_w, dmem_w, m1_num, halted}
    function automatic void expect_cycle(input logic [4:0] st);
        sb.push_back({st, exp_ill, exp_ret});
    endfunction

    function automatic logic [10:0] sels();
        return {alu_funct, m1_num, m2_num, m3_num, m4_num, m5_num, m6_num, m7_num};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; opcode = OP_R; funct = 4'd1;
        tick();
        vectors++;
        if (got() !== vec_t'(0)) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", got(), vec_t'(0));
        end
        vectors++;
        if (sels() !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_sel_forced: got %h want 000", sels());
        end
        tick();
        rst = 1'b0;
        exp_ret = '0; exp_ill = 1'b0;
    endtask

    task automatic test_rtype();
        opcode = OP_R; funct = 4'd1;
        #1;
        vectors++;
        if (sels() !== {4'd1, 7'b0011000}) begin
            miscompares++;
            $display("FAIL rtype_sel: got %h want %h", sels(), {4'd1, 7'b0011000});
        end
        expect_cycle(5'b00000);
        expect_cycle(5'b11000);
        exp_ret++;
        expect_cycle(5'b00000);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            vectors++;
            if (got() !== e) begin
                miscompares++;
                $display("FAIL rtype: got %h want %h", got(), e);
            end
        end
    endtask

    task automatic test_store();
        opcode = OP_SW;
        #1;
        vectors++;
        if (sels() !== {4'd0, 7'b0000110}) begin
            miscompares++;
            $display("FAIL store_sel: got %h want %h", sels(), {4'd0, 7'b0000110});
        end
        expect_cycle(5'b00000);
        expect_cycle(5'b00100);
        expect_cycle(5'b10000);
        exp_ret++;
        expect_cycle(5'b00000);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            vectors++;
            if (got() !== e) begin
                miscompares++;
                $display("FAIL store: got %h want %h", got(), e);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops[2];
        ops[0] = OP_BEQ; ops[1] = OP_BNE;
        for (int b = 0; b < 2; b++) begin
            opcode = ops[b]; alu_zero = 1'b1;
            #1;
            vectors++;
            if (sels() !== {4'd1, 7'b0000000}) begin
                miscompares++;
                $display("FAIL branch_sel op%0h: got %h want %h", ops[b], sels(), {4'd1, 7'b0});
            end
            expect_cycle(5'b00000);
            expect_cycle(b == 0 ? 5'b10010 : 5'b10000);
            exp_ret++;
            expect_cycle(5'b00000);
            for (int i = 0; i < 3; i++) begin
                tick();
                if (i == 1) alu_zero = 1'b0;
                e = sb.pop_front();
                vectors++;
                if (got() !== e) begin
                    miscompares++;
                    $display("FAIL branch op%0h cyc%0d: got %h want %h", ops[b], i, got(), e);
                end
            end
        end
    endtask

    task automatic test_jump();
        opcode = OP_J;
        #1;
        vectors++;
        if (sels() !== {4'd0, 7'b0100000}) begin
            miscompares++;
            $display("FAIL jump_sel: got %h want %h", sels(), {4'd0, 7'b0100000});
        end
        expect_cycle(5'b00000);
        expect_cycle(5'b10000);
        exp_ret++;
        expect_cycle(5'b00000);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            vectors++;
            if (got() !== e) begin
                miscompares++;
                $display("FAIL jump: got %h want %h", got(), e);
            end
        end
    endtask

    task automatic test_illegal();
        // Undefined opcode runs as a NOP, then an ADDI shows the flag is sticky.
        opcode = 6'h20;
        #1;
        vectors++;
        if (sels() !== 11'd0) begin
            miscompares++;
            $display("FAIL illegal_sel: got %h want 000", sels());
        end
        expect_cycle(5'b00000);
        exp_ill = 1'b1;
        expect_cycle(5'b10000);
        exp_ret++;
        expect_cycle(5'b00000);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            vectors++;
            if (got() !== e) begin
                miscompares++;
                $display("FAIL illegal: got %h want %h", got(), e);
            end
        end
        opcode = OP_ADDI;
        #1;
        vectors++;
        if (sels() !== {4'd0, 7'b0010010}) begin
            miscompares++;
            $display("FAIL addi_sel: got %h want %h", sels(), {4'd0, 7'b0010010});
        end
        expect_cycle(5'b00000);
        expect_cycle(5'b11000);
        exp_ret++;
        expect_cycle(5'b00000);
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            vectors++;
            if (got() !== e) begin
                miscompares++;
                $display("FAIL illegal_sticky: got %h want %h", got(), e);
            end
        end
    endtask

    task automatic test_lw_abort();
        opcode = OP_LW;
        #1;
        vectors++;
        if (sels() !== {4'd0, 7'b0010011}) begin
            miscompares++;
            $display("FAIL lw_sel: got %h want %h", sels(), {4'd0, 7'b0010011});
        end
        expect_cycle(5'b00000);
        expect_cycle(5'b00000);
        expect_cycle(5'b00000);
        exp_ret = '0; exp_ill = 1'b0;
        expect_cycle(5'b00000);
        expect_cycle(5'b00000);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rst = 1'b1;
                #1;
                vectors++;
                if (m7_num !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lw_rst_sel: got m7=%b want 0", m7_num);
                end
            end else begin
                tick();
            end
            if (i == 3) begin
                rst = 1'b0; run = 1'b0;
            end
            e = sb.pop_front();
            vectors++;
            if (got() !== e) begin
                miscompares++;
                $display("FAIL lw_abort cyc%0d: got %h want %h", i, got(), e);
            end
        end
        run = 1'b1;
    endtask

    task automatic test_halt();
        opcode = OP_HALT; run = 1'b1;
        expect_cycle(5'b00000);
        for (int i = 0; i < 21; i++) expect_cycle(5'b00001);
        for (int i = 0; i < 22; i++) begin
            tick();
            if (i >= 1) run = ~run;
            if (i == 5) begin
                opcode = OP_R;
                #1;
                vectors++;
                if (sels() !== 11'd0) begin
                    miscompares++;
                    $display("FAIL halt_sel_forced: got %h want 000", sels());
                end
            end
            e = sb.pop_front();
            vectors++;
            if (got() !== e) begin
                miscompares++;
                $display("FAIL halt cyc%0d: got %h want %h", i, got(), e);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (got() !== vec_t'(0)) begin
            miscompares++;
            $display("FAIL halt_reset: got %h want %h", got(), vec_t'(0));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_store();
        test_branch();
        test_jump();
        test_illegal();
        test_lw_abort();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
